// File: rtl/vexec_pkg.sv
// Shared types for the vector execute stage: opcodes, condition codes,
// flag bit positions, FSM states and the condition evaluation helper.
package vexec_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SHL  = 3'd5,
    OP_ROR  = 3'd6,
    OP_SWAP = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    COND_AL = 2'd0,  // always
    COND_EQ = 2'd1,  // Z set
    COND_NE = 2'd2,  // Z clear
    COND_MI = 2'd3   // N set
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // True when an op issued under condition c should execute given flags f.
  function automatic logic cond_pass(cond_e c, logic [3:0] f);
    logic ok;
    case (c)
      COND_AL: ok = 1'b1;
      COND_EQ: ok = f[FLAG_Z];
      COND_NE: ok = !f[FLAG_Z];
      COND_MI: ok = f[FLAG_N];
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/vexec_stage_if.sv
// Bundle of the operand/op handshake and the result handshake of vexec_stage.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. The source holds valid and its payload steady until that edge;
// the sink may raise or drop ready freely. Upstream uses valid_i/ready_o,
// downstream uses valid_o/ready_i. flush_i is a plain level control.
interface vexec_stage_if #(
  parameter int REGI_SIZE = 16,
  parameter int ELEM_SIZE = 8,
  parameter int VECT_SIZE = 8
);
  logic                           flush_i;
  logic                           valid_i;
  logic                           ready_o;
  logic [2:0]                     opcode_i;
  logic [1:0]                     cond_i;
  logic                           imm_en_i;
  logic [7:0]                     imm_i;
  logic [REGI_SIZE-1:0]           int_rsa_i;
  logic [REGI_SIZE-1:0]           int_rsb_i;
  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_rsa_i;
  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_rsb_i;
  logic [2:0]                     swap_src_i;
  logic [2:0]                     swap_dst_i;
  logic                           valid_o;
  logic                           ready_i;
  logic [REGI_SIZE-1:0]           ialu_res_o;
  logic [ELEM_SIZE*VECT_SIZE-1:0] valu_res_o;
  logic [3:0]                     alu_flags_o;

  modport slave (
    input  flush_i, valid_i, opcode_i, cond_i, imm_en_i, imm_i,
           int_rsa_i, int_rsb_i, vec_rsa_i, vec_rsb_i,
           swap_src_i, swap_dst_i, ready_i,
    output ready_o, valid_o, ialu_res_o, valu_res_o, alu_flags_o
  );

  modport master (
    output flush_i, valid_i, opcode_i, cond_i, imm_en_i, imm_i,
           int_rsa_i, int_rsb_i, vec_rsa_i, vec_rsb_i,
           swap_src_i, swap_dst_i, ready_i,
    input  ready_o, valid_o, ialu_res_o, valu_res_o, alu_flags_o
  );
endinterface

// File: rtl/vexec_elem_alu.sv
// Combinational ALU for one operand pair of arbitrary width. Carry and
// overflow are only meaningful for ADD/SUB and read as 0 otherwise.
module vexec_elem_alu
  import vexec_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       swap_src_i,
  input  logic [2:0]       swap_dst_i,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             ovf_o
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH:0]    sum_add;
  logic [WIDTH:0]    sum_sub;
  logic [SH_W-1:0]   sh;
  logic [SH_W-1:0]   src_idx;
  logic [SH_W-1:0]   dst_idx;

  assign sh      = b_i[SH_W-1:0];
  assign src_idx = SH_W'(swap_src_i);
  assign dst_idx = SH_W'(swap_dst_i);
  assign sum_add = {1'b0, a_i} + {1'b0, b_i};
  // a + ~b + 1: the top bit is the no-borrow indication.
  assign sum_sub = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};

  // Opcode decode; pass a through by default.
  always_comb begin
    res_o   = a_i;
    carry_o = 1'b0;
    ovf_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o   = sum_add[WIDTH-1:0];
        carry_o = sum_add[WIDTH];
        ovf_o   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_add[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res_o   = sum_sub[WIDTH-1:0];
        carry_o = sum_sub[WIDTH];
        ovf_o   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sum_sub[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_SHL:  res_o = a_i << sh;
      OP_ROR:  res_o = (a_i >> sh) | (a_i << (WIDTH - int'(sh)));
      OP_SWAP: begin
        res_o          = a_i;
        res_o[src_idx] = a_i[dst_idx];
        res_o[dst_idx] = a_i[src_idx];
      end
      default: res_o = a_i;
    endcase
  end
endmodule

// File: rtl/vexec_stage.sv
// Multi-beat execute stage: latches an op, runs VECT_LANES vector elements
// per beat (integer result on beat 0), updates NZCV on the last beat and
// holds the result until the memory stage takes it.
module vexec_stage
  import vexec_pkg::*;
#(
  parameter int REGI_SIZE  = 16,
  parameter int ELEM_SIZE  = 8,
  parameter int VECT_SIZE  = 8,
  parameter int VECT_LANES = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  vexec_stage_if.slave  bus,
  output state_e        state_o
);
  localparam int BEATS = VECT_SIZE / VECT_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW    = ELEM_SIZE * VECT_SIZE;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  op_e                  op_q;
  logic                 cond_ok_q;
  logic [REGI_SIZE-1:0] int_a_q, int_b_q;
  logic [VW-1:0]        vec_a_q, vec_b_q;
  logic [2:0]           swap_src_q, swap_dst_q;
  logic [REGI_SIZE-1:0] int_res_q;
  logic [VW-1:0]        vec_res_q;
  logic [3:0]           flags_q;

  logic                 accept;
  logic                 last_beat;
  logic [ELEM_SIZE-1:0] imm_elem;
  logic [REGI_SIZE-1:0] ialu_res;
  logic                 ialu_carry, ialu_ovf;
  logic [ELEM_SIZE-1:0] lane_a   [VECT_LANES];
  logic [ELEM_SIZE-1:0] lane_b   [VECT_LANES];
  logic [ELEM_SIZE-1:0] lane_res [VECT_LANES];
  logic [VECT_LANES-1:0] lane_unused_c, lane_unused_v;

  assign accept    = (state_q == ST_IDLE) && bus.valid_i && !bus.flush_i;
  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign imm_elem  = ELEM_SIZE'(bus.imm_i);

  assign bus.ready_o     = (state_q == ST_IDLE);
  assign bus.valid_o     = (state_q == ST_HOLD);
  assign bus.ialu_res_o  = int_res_q;
  assign bus.valu_res_o  = vec_res_q;
  assign bus.alu_flags_o = flags_q;
  assign state_o         = state_q;

  // State register; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: flush returns to IDLE from anywhere and blocks acceptance.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (!bus.flush_i && bus.valid_i) state_d = ST_RUN;
      ST_RUN:  begin
        if (bus.flush_i)    state_d = ST_IDLE;
        else if (last_beat) state_d = ST_HOLD;
      end
      ST_HOLD: if (bus.flush_i || bus.ready_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  vexec_elem_alu #(.WIDTH(REGI_SIZE)) u_int_alu (
    .op_i       (op_q),
    .a_i        (int_a_q),
    .b_i        (int_b_q),
    .swap_src_i (swap_src_q),
    .swap_dst_i (swap_dst_q),
    .res_o      (ialu_res),
    .carry_o    (ialu_carry),
    .ovf_o      (ialu_ovf)
  );

  for (genvar g = 0; g < VECT_LANES; g++) begin : g_lane
    assign lane_a[g] = vec_a_q[(int'(cnt_q) * VECT_LANES + g) * ELEM_SIZE +: ELEM_SIZE];
    assign lane_b[g] = vec_b_q[(int'(cnt_q) * VECT_LANES + g) * ELEM_SIZE +: ELEM_SIZE];

    vexec_elem_alu #(.WIDTH(ELEM_SIZE)) u_lane_alu (
      .op_i       (op_q),
      .a_i        (lane_a[g]),
      .b_i        (lane_b[g]),
      .swap_src_i (swap_src_q),
      .swap_dst_i (swap_dst_q),
      .res_o      (lane_res[g]),
      .carry_o    (lane_unused_c[g]),
      .ovf_o      (lane_unused_v[g])
    );
  end

  // Operand latch, beat-wise result write-back and flag update. A failed
  // condition writes the a operands back so beat timing is unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      cond_ok_q  <= 1'b0;
      int_a_q    <= '0;
      int_b_q    <= '0;
      vec_a_q    <= '0;
      vec_b_q    <= '0;
      swap_src_q <= '0;
      swap_dst_q <= '0;
      int_res_q  <= '0;
      vec_res_q  <= '0;
      flags_q    <= '0;
    end else if (!bus.flush_i) begin
      if (accept) begin
        cnt_q      <= '0;
        op_q       <= op_e'(bus.opcode_i);
        cond_ok_q  <= cond_pass(cond_e'(bus.cond_i), flags_q);
        int_a_q    <= bus.int_rsa_i;
        int_b_q    <= bus.imm_en_i ? REGI_SIZE'(bus.imm_i) : bus.int_rsb_i;
        vec_a_q    <= bus.vec_rsa_i;
        vec_b_q    <= bus.imm_en_i ? {VECT_SIZE{imm_elem}} : bus.vec_rsb_i;
        swap_src_q <= bus.swap_src_i;
        swap_dst_q <= bus.swap_dst_i;
      end else if (state_q == ST_RUN) begin
        for (int l = 0; l < VECT_LANES; l++) begin
          vec_res_q[(int'(cnt_q) * VECT_LANES + l) * ELEM_SIZE +: ELEM_SIZE] <=
            cond_ok_q ? lane_res[l] : lane_a[l];
        end
        if (cnt_q == '0) int_res_q <= cond_ok_q ? ialu_res : int_a_q;
        if (last_beat) begin
          cnt_q <= '0;
          if (cond_ok_q) begin
            flags_q[FLAG_N] <= ialu_res[REGI_SIZE-1];
            flags_q[FLAG_Z] <= (ialu_res == '0);
            flags_q[FLAG_C] <= ialu_carry;
            flags_q[FLAG_V] <= ialu_ovf;
          end
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_vexec_stage.sv
// Directed bench for vexec_stage: a driver issues ops and queues the
// hand-computed results; a monitor pops and compares on each result
// handshake and checks accept-to-valid latency.
module tb_vexec_stage;
  import vexec_pkg::*;

  localparam int RW    = 16;
  localparam int EW    = 8;
  localparam int VS    = 8;
  localparam int VL    = 2;
  localparam int BEATS = VS / VL;
  localparam int VW    = EW * VS;
  localparam int XW    = RW + VW + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  vexec_stage_if #(.REGI_SIZE(RW), .ELEM_SIZE(EW), .VECT_SIZE(VS)) bus ();
  vexec_stage_if #(.REGI_SIZE(RW), .ELEM_SIZE(EW), .VECT_SIZE(VS)) bus2 ();
  state_e st, st2;

  vexec_stage #(.REGI_SIZE(RW), .ELEM_SIZE(EW), .VECT_SIZE(VS), .VECT_LANES(VL)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .state_o(st)
  );

  vexec_stage #(.REGI_SIZE(RW), .ELEM_SIZE(EW), .VECT_SIZE(VS), .VECT_LANES(VS)) dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2), .state_o(st2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [XW-1:0] exp_q[$];
  int            acc_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    bus.valid_i    = 1'b0;
    bus.opcode_i   = '0;
    bus.cond_i     = '0;
    bus.imm_en_i   = 1'b0;
    bus.imm_i      = '0;
    bus.int_rsa_i  = '0;
    bus.int_rsb_i  = '0;
    bus.vec_rsa_i  = '0;
    bus.vec_rsb_i  = '0;
    bus.swap_src_i = '0;
    bus.swap_dst_i = '0;
  endtask

  task automatic send(input logic [2:0] op, input logic [1:0] cond, input logic imm_en,
                      input logic [7:0] imm, input logic [RW-1:0] a, input logic [RW-1:0] b,
                      input logic [VW-1:0] va, input logic [VW-1:0] vb,
                      input logic [2:0] src, input logic [2:0] dst, input bit track,
                      input logic [RW-1:0] ei, input logic [VW-1:0] ev, input logic [3:0] ef);
    int n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("send_ready_timeout");
    bus.opcode_i   = op;
    bus.cond_i     = cond;
    bus.imm_en_i   = imm_en;
    bus.imm_i      = imm;
    bus.int_rsa_i  = a;
    bus.int_rsb_i  = b;
    bus.vec_rsa_i  = va;
    bus.vec_rsb_i  = vb;
    bus.swap_src_i = src;
    bus.swap_dst_i = dst;
    bus.valid_i    = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    if (track) begin
      exp_q.push_back({ei, ev, ef});
      acc_q.push_back(cyc);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!bus.ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_idle_timeout");
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!bus.valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("wait_valid_timeout");
  endtask

  // ---------------- monitor ----------------
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    int a;
    logic [XW-1:0] e;
    if (rst) begin
      prev_v <= 1'b0;
    end else begin
      if (bus.valid_o && !prev_v) begin
        if (acc_q.size() == 0) fail_now("unexpected_valid_o");
        else begin
          a = acc_q.pop_front();
          check("latency", 128'(cyc - a), 128'(BEATS));
        end
      end
      if (bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) fail_now("result_without_expectation");
        else begin
          e = exp_q.pop_front();
          check("ialu_res", 128'(bus.ialu_res_o), 128'(e[XW-1 -: RW]));
          check("valu_res", 128'(bus.valu_res_o), 128'(e[VW+3:4]));
          check("alu_flags", 128'(bus.alu_flags_o), 128'(e[3:0]));
        end
      end
      prev_v <= bus.valid_o;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst         = 1'b1;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b1;
    idle_inputs();
    bus2.flush_i = 1'b0; bus2.ready_i = 1'b1; bus2.valid_i = 1'b0;
    bus2.opcode_i = '0; bus2.cond_i = '0; bus2.imm_en_i = 1'b0; bus2.imm_i = '0;
    bus2.int_rsa_i = '0; bus2.int_rsb_i = '0; bus2.vec_rsa_i = '0; bus2.vec_rsb_i = '0;
    bus2.swap_src_i = '0; bus2.swap_dst_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_o", 128'(bus.ready_o), 128'(1));
    check("rst_valid_o", 128'(bus.valid_o), 128'(0));
    check("rst_flags", 128'(bus.alu_flags_o), 128'(0));
    check("rst_ialu", 128'(bus.ialu_res_o), 128'(0));
    check("rst_valu", 128'(bus.valu_res_o), 128'(0));
    rst = 1'b0;

    // op, cond, imm_en, imm, a, b, va, vb, src, dst, track, exp int, exp vec, exp flags {N,Z,C,V}
    send(OP_ADD, COND_AL, 0, 8'h00, 16'h00FF, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h0100, 64'h0, 4'b0000);
    send(OP_SUB, COND_AL, 0, 8'h00, 16'h0005, 16'h0005, 64'h0807_0605_0403_0201, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h0000, 64'h0706_0504_0302_0100, 4'b0110);
    send(OP_ADD, COND_EQ, 1, 8'h01, 16'hFFFF, 16'h5555, 64'h1020_3040_5060_7080, 64'h0, 0, 0, 1, 16'h0000, 64'h1121_3141_5161_7181, 4'b0110);
    send(OP_ADD, COND_NE, 0, 8'h00, 16'h1234, 16'h4321, 64'hDEAD_BEEF_0123_4567, 64'h1111_1111_1111_1111, 0, 0, 1, 16'h1234, 64'hDEAD_BEEF_0123_4567, 4'b0110);
    send(OP_SWAP, COND_AL, 0, 8'h00, 16'h0001, 16'hFFFF, 64'h0101_0101_0101_0101, 64'h0, 3'd0, 3'd7, 1, 16'h0080, 64'h8080_8080_8080_8080, 4'b0000);
    send(OP_SUB, COND_AL, 0, 8'h00, 16'h8000, 16'h0001, 64'h0, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0011);
    send(OP_SHL, COND_AL, 0, 8'h00, 16'h0003, 16'h0014, 64'h0F0F_0F0F_0F0F_0F0F, 64'h0C0C_0C0C_0C0C_0C0C, 0, 0, 1, 16'h0030, 64'hF0F0_F0F0_F0F0_F0F0, 4'b0000);
    send(OP_ROR, COND_AL, 1, 8'h01, 16'h0001, 16'h0000, 64'h8181_8181_8181_8181, 64'h0, 0, 0, 1, 16'h8000, 64'hC0C0_C0C0_C0C0_C0C0, 4'b1000);
    send(OP_ADD, COND_MI, 0, 8'h00, 16'h0001, 16'h0001, 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h0002, 64'h0202_0202_0202_0202, 4'b0000);
    send(OP_ADD, COND_MI, 0, 8'h00, 16'h7777, 16'h0001, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h7777, 64'h1111_2222_3333_4444, 4'b0000);
    send(OP_XOR, COND_AL, 0, 8'h00, 16'hAAAA, 16'hAAAA, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100);

    // Result held while the memory stage stalls.
    wait_idle();
    bus.ready_i = 1'b0;
    send(OP_AND, COND_AL, 0, 8'h00, 16'hF0F0, 16'h0FF0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 0, 0, 1, 16'h00F0, 64'h0204_0608_0A0C_0E00, 4'b0000);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      check("hold_ialu", 128'(bus.ialu_res_o), 128'(16'h00F0));
      check("hold_valu", 128'(bus.valu_res_o), 128'(64'h0204_0608_0A0C_0E00));
      check("hold_flags", 128'(bus.alu_flags_o), 128'(0));
      check("hold_ready_o", 128'(bus.ready_o), 128'(0));
      check("hold_valid_o", 128'(bus.valid_o), 128'(1));
      @(negedge clk);
    end
    @(posedge clk);
    #1 bus.ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("release_ready_o", 128'(bus.ready_o), 128'(1));
    check("release_valid_o", 128'(bus.valid_o), 128'(0));
    send(OP_OR, COND_AL, 0, 8'h00, 16'h8000, 16'h0001, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 1, 16'h8001, 64'h0123_4567_89AB_CDEF, 4'b1000);

    // Flush during beat 2: no result, flags untouched.
    wait_idle();
    send(OP_SUB, COND_AL, 0, 8'h00, 16'h0005, 16'h0003, 64'h0, 64'h0, 0, 0, 0, 16'h0, 64'h0, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pre_flush_state", 128'(st), 128'(ST_RUN));
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_state", 128'(st), 128'(ST_IDLE));
    check("flush_ready_o", 128'(bus.ready_o), 128'(1));
    check("flush_flags", 128'(bus.alu_flags_o), 128'(4'b1000));
    for (int i = 0; i < 6; i++) begin
      check("flush_valid_o", 128'(bus.valid_o), 128'(0));
      @(negedge clk);
    end
    send(OP_ADD, COND_MI, 0, 8'h00, 16'h0002, 16'h0003, 64'h0505_0505_0505_0505, 64'h0303_0303_0303_0303, 0, 0, 1, 16'h0005, 64'h0808_0808_0808_0808, 4'b0000);

    // Reset in the middle of RUN clears every output.
    wait_idle();
    send(OP_ADD, COND_AL, 0, 8'h00, 16'h7FFF, 16'h0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 16'h0, 64'h0, 4'b0000);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ialu", 128'(bus.ialu_res_o), 128'(0));
    check("midrst_valu", 128'(bus.valu_res_o), 128'(0));
    check("midrst_flags", 128'(bus.alu_flags_o), 128'(0));
    check("midrst_valid_o", 128'(bus.valid_o), 128'(0));
    check("midrst_ready_o", 128'(bus.ready_o), 128'(1));
    rst = 1'b0;
    send(OP_ADD, COND_EQ, 0, 8'h00, 16'h4242, 16'h0001, 64'hCAFE_BABE_1234_5678, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h4242, 64'hCAFE_BABE_1234_5678, 4'b0000);
    send(OP_ADD, COND_AL, 0, 8'h00, 16'h7FFF, 16'h0001, 64'h7F7F_7F7F_7F7F_7F7F, 64'h0101_0101_0101_0101, 0, 0, 1, 16'h8000, 64'h8080_8080_8080_8080, 4'b1001);

    n = 0;
    while ((exp_q.size() != 0 || !bus.ready_o) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("drain_timeout");

    // All-lanes build: one beat per op.
    @(negedge clk);
    check("l8_ready_o", 128'(bus2.ready_o), 128'(1));
    bus2.opcode_i  = OP_ROR;
    bus2.int_rsa_i = 16'h0081;
    bus2.int_rsb_i = 16'h0001;
    bus2.vec_rsa_i = 64'h8181_8181_8181_8181;
    bus2.vec_rsb_i = 64'h0101_0101_0101_0101;
    bus2.valid_i   = 1'b1;
    @(posedge clk);
    #1 bus2.valid_i = 1'b0;
    @(negedge clk);
    check("l8_run_valid_o", 128'(bus2.valid_o), 128'(0));
    @(negedge clk);
    check("l8_valid_o", 128'(bus2.valid_o), 128'(1));
    check("l8_ialu", 128'(bus2.ialu_res_o), 128'(16'h8040));
    check("l8_valu", 128'(bus2.valu_res_o), 128'(64'hC0C0_C0C0_C0C0_C0C0));
    check("l8_flags", 128'(bus2.alu_flags_o), 128'(4'b1000));
    @(negedge clk);
    check("l8_back_idle", 128'(bus2.ready_o), 128'(1));

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end
endmodule
